// File: rtl/mul_div_pkg.sv
// Shared types and defaults for the RV32M multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    // The remainder stays below the divisor, so its msb is always zero before the shift.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_i[WIDTH];

    always_comb begin
        shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        ge      = (shifted >= {1'b0, divisor_i});
        rem_o   = ge ? diff : shifted;
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; special cases finish in one cycle.
module seq_divider
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             sel_rem_q, sel_rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_op_t          op;
    logic             op_signed;
    logic             div_by_zero;
    logic             overflow;
    logic             special;
    logic             accept;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] fix_val;
    logic             fix_neg;
    logic [WIDTH-1:0] fix_res;

    assign op          = div_op_t'(op_i);
    assign op_signed   = (op == DIV) || (op == REM);
    assign div_by_zero = (divisor_i == '0);
    assign overflow    = op_signed && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                         && (divisor_i == '1);
    assign special     = div_by_zero || overflow;
    assign accept      = (state_q == IDLE) && start_i && !flush_i;

    always_comb begin
        if (div_by_zero) begin
            special_res = op_i[1] ? dividend_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : dividend_i;
        end
    end

    assign fix_val = sel_rem_q ? rem_q[WIDTH-1:0] : quo_q;
    assign fix_neg = sel_rem_q ? rneg_q : qneg_q;
    assign fix_res = fix_neg ? -fix_val : fix_val;

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i && !special) state_d = ITER;
                ITER:    if (cnt_q == '0) state_d = FIX;
                FIX:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sel_rem_d = op_i[1];
                    if (special) begin
                        result_d = special_res;
                        done_d   = 1'b1;
                    end else begin
                        rem_d  = '0;
                        quo_d  = (op_signed && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
                        dvs_d  = (op_signed && divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
                        qneg_d = op_signed && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        rneg_d = op_signed && dividend_i[WIDTH-1];
                        cnt_d  = CntW'(WIDTH - 1);
                    end
                end
            end
            ITER: begin
                if (!flush_i) begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (!flush_i) begin
                    result_d = fix_res;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        busy_o   = (state_q != IDLE);
        done_o   = done_q;
        result_o = result_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random ops vs an arithmetic model.
module tb_seq_divider;
    import mul_div_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int           checks   = 0;
    int           failures = 0;
    logic [31:0]  last_res;
    logic [31:0]  got;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .op_i      (op),
        .dividend_i(dividend),
        .divisor_i (divisor),
        .flush_i   (flush),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics via 64-bit integer arithmetic (truncating toward zero).
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Start an op in the current cycle (cycle 0) and check busy/done/result cycle by cycle.
    // poke_at > 0 re-asserts start with other operands in that cycle; it must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input string tag, output logic [31:0] res);
        logic [31:0] exp;
        bit          sp;
        int          lat;
        exp      = model(o, a, b);
        sp       = is_special(o, a, b);
        lat      = sp ? 1 : W + 2;
        res      = 32'hDEAD_BEEF;
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int k = 1; k <= W + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                op       = 2'($urandom_range(0, 3));
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (k == poke_at) begin
                start    = 1'b1;
                op       = DIVU;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            if (poke_at > 0 && k == poke_at + 1) start = 1'b0;
            chk({tag, " busy"}, 32'(busy), 32'(!sp && k <= W + 1));
            chk({tag, " done"}, 32'(done), 32'(k == lat));
            if (k == lat) begin
                chk({tag, " result"}, result, exp);
                res      = result;
                last_res = exp;
                break;
            end else begin
                chk({tag, " result hold"}, result, last_res);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(DIVU, 32'd100, 32'd7, 0, "divu_100_7", got);
        chk("divu_100_7 value", got, 32'd14);
        run_op(REMU, 32'd100, 32'd7, 0, "remu_100_7", got);
        chk("remu_100_7 value", got, 32'd2);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2", got);
        chk("div_m7_2 value", got, 32'hFFFF_FFFD);
        run_op(REM, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2", got);
        chk("rem_m7_2 value", got, 32'hFFFF_FFFF);
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2", got);
        chk("div_7_m2 value", got, 32'hFFFF_FFFD);
        run_op(DIVU, 32'h1234_5678, 32'd0, 0, "divu_by0", got);
        chk("divu_by0 value", got, 32'hFFFF_FFFF);
        run_op(REM, 32'h1234_5678, 32'd0, 0, "rem_by0", got);
        chk("rem_by0 value", got, 32'h1234_5678);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf", got);
        chk("div_ovf value", got, 32'h8000_0000);
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf", got);
        chk("rem_ovf value", got, 32'h0);

        // One idle cycle first so the ignored-start op begins from a quiet IDLE.
        @(negedge clk);
        run_op(DIVU, 32'd1000, 32'd3, 5, "ignore_start", got);
        chk("ignore_start value", got, 32'd333);

        // Flush an op started the cycle after that done (cycle 35) in cycle 40.
        @(negedge clk);
        op       = DIVU;
        dividend = $urandom;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush done", 32'(done), 32'd0);
        chk("flush result", result, 32'd333);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("flush no done", 32'(done), 32'd0);
        end
        chk("flush result kept", result, 32'd333);

        // flush coincident with start in IDLE drops the start, special or not.
        op       = DIVU;
        dividend = 32'd5;
        divisor  = 32'd0;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("idle flush special done", 32'(done), 32'd0);
        chk("idle flush special result", result, 32'd333);
        divisor = 32'd5;
        start   = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("idle flush normal busy", 32'(busy), 32'd0);

        // Synchronous reset mid-operation.
        op       = DIV;
        dividend = 32'hFFFF_CFC7;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset result", result, 32'd0);
        last_res = 32'd0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("midreset no done", 32'(done), 32'd0);
        end
        run_op(DIVU, 32'hFFFF_FFFF, 32'h10, 0, "after_reset", got);
        chk("after_reset value", got, 32'h0FFF_FFFF);

        // Random back-to-back ops with a bias toward the corner cases.
        for (int n = 0; n < 40; n++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: rb = 32'h0;
                1: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                2: rb = $urandom_range(1, 15);
                3: rb = -$urandom_range(1, 15);
                4: ra = $urandom_range(0, 255);
                default: ;
            endcase
            run_op(ro, ra, rb, 0, "rand", got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
